// File: rtl/seg7_scroll_display_pkg.sv
// Shared constants and position-code type for the scrolling 7-segment display.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package seg7_scroll_display_pkg;

  localparam int NUM_DIGITS = 5;
  localparam int NUM_POS    = 6;
  localparam int MAX_OFFSET = 2;
  localparam int NUM_AN     = 4;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  typedef enum logic [1:0] {
    POS_DIGIT = 2'd0,
    POS_BLANK = 2'd1,
    POS_MINUS = 2'd2
  } pos_kind_e;

  typedef struct packed {
    pos_kind_e  kind;
    logic [3:0] digit;
  } pos_code_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational mapping of one field position code to active-low segments.
module seg7_decode
  import seg7_scroll_display_pkg::*;
(
  input  pos_code_t  code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code.kind)
      POS_MINUS: seg = SEG_MINUS;
      POS_DIGIT: begin
        case (code.digit)
          4'd0:    seg = SEG_ZERO;
          4'd1:    seg = 7'b1111001;
          4'd2:    seg = 7'b0100100;
          4'd3:    seg = 7'b0110000;
          4'd4:    seg = 7'b0011001;
          4'd5:    seg = 7'b0010010;
          4'd6:    seg = 7'b0000010;
          4'd7:    seg = 7'b1111000;
          4'd8:    seg = 7'b0000000;
          4'd9:    seg = 7'b0010000;
          default: seg = SEG_E;
        endcase
      end
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scroll_display.sv
// Four-digit multiplexed display of a captured 5-digit signed BCD value,
// with a 3-position scrolling window over a 6-position field.
module seg7_scroll_display
  import seg7_scroll_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit SIM_FAST    = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] bcd,
  input  logic        sign,
  input  logic        load,
  input  logic        scroll_left,
  input  logic        scroll_right,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int DIV_EFF = SIM_FAST ? 4 : REFRESH_DIV;
  localparam int CNT_W   = (DIV_EFF > 1) ? $clog2(DIV_EFF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_EFF - 1);
  localparam logic [1:0] OFFSET_MAX = 2'(MAX_OFFSET);

  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       sel_reg;
  logic [1:0]       offset_reg;
  logic [19:0]      bcd_reg;
  logic             sign_reg;

  // Scan timing is free-running; loads never disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      sel_reg <= '0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_reg <= '0;
      sel_reg <= sel_reg + 2'd1;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_reg    <= '0;
      sign_reg   <= 1'b0;
      offset_reg <= '0;
    end else if (load) begin
      bcd_reg    <= bcd;
      sign_reg   <= sign;
      offset_reg <= '0;
    end else if (scroll_left && !scroll_right) begin
      if (offset_reg != OFFSET_MAX) offset_reg <= offset_reg + 2'd1;
    end else if (scroll_right && !scroll_left) begin
      if (offset_reg != 2'd0) offset_reg <= offset_reg - 2'd1;
    end
  end

  logic [2:0] msd;
  logic       show_minus;

  always_comb begin
    msd = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_reg[4*i +: 4] != 4'd0) msd = 3'(i);
    end
  end

  assign show_minus = sign_reg && (bcd_reg != '0);

  pos_code_t field [NUM_POS];

  // Position 0 always shows its digit so a zero value still reads '0'.
  generate
    for (genvar gi = 0; gi < NUM_POS; gi++) begin : g_field
      if (gi == 0) begin : g_units
        assign field[gi] = pos_code_t'{POS_DIGIT, bcd_reg[3:0]};
      end else if (gi < NUM_DIGITS) begin : g_digit
        assign field[gi] =
          (3'(gi) <= msd)                          ? pos_code_t'{POS_DIGIT, bcd_reg[4*gi +: 4]} :
          ((3'(gi) == msd + 3'd1) && show_minus)   ? pos_code_t'{POS_MINUS, 4'd0} :
                                                     pos_code_t'{POS_BLANK, 4'd0};
      end else begin : g_spare
        assign field[gi] = ((3'(gi) == msd + 3'd1) && show_minus)
                           ? pos_code_t'{POS_MINUS, 4'd0}
                           : pos_code_t'{POS_BLANK, 4'd0};
      end
    end
  endgenerate

  logic [2:0] pos_idx;
  pos_code_t  cur_code;
  logic [6:0] seg_next;
  logic [3:0] an_next;
  logic       dp_next;

  assign pos_idx  = {1'b0, offset_reg} + {1'b0, sel_reg};
  assign cur_code = field[pos_idx];
  assign an_next  = ~(4'b0001 << sel_reg);
  assign dp_next  = ~((sel_reg == 2'd0) && (offset_reg != 2'd0));

  seg7_decode u_decode (
    .code (cur_code),
    .seg  (seg_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_seg7_scroll_display.sv
// Self-checking bench: directed scenarios plus random pulses, compared each
// clock against a digit-array model of the display field and scan slot.
module tb_seg7_scroll_display;

  logic        clk;
  logic        rst_n;
  logic [19:0] bcd;
  logic        sign;
  logic        load;
  logic        scroll_left;
  logic        scroll_right;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int vectors;
  int miscompares;

  // Reference model state
  int m_dig [5];
  bit m_sign;
  int m_off;
  int edge_cnt;

  seg7_scroll_display #(
    .REFRESH_DIV (100000),
    .SIM_FAST    (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bcd          (bcd),
    .sign         (sign),
    .load         (load),
    .scroll_left  (scroll_left),
    .scroll_right (scroll_right),
    .an           (an),
    .seg          (seg),
    .dp           (dp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] digit_seg(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    if (d > 9) return 7'b0000110;
    return tbl[d];
  endfunction

  // Character shown at physical digit k from the model's value and window.
  function automatic logic [6:0] model_seg(input int k);
    int pos;
    int top;
    bit nz;
    pos = m_off + k;
    top = 0;
    nz  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (m_dig[i] != 0) begin
        top = i;
        nz  = 1'b1;
      end
    end
    if (pos <= top) return digit_seg(m_dig[pos]);
    if (pos == top + 1 && m_sign && nz) return 7'b0111111;
    return 7'b1111111;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_dig[i] = 0;
    m_sign   = 1'b0;
    m_off    = 0;
    edge_cnt = 0;
  endtask

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: {an,seg,dp} got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, predict from pre-edge model state, advance model, check.
  task automatic cycle(input bit ld, input bit sl, input bit sr,
                       input logic [19:0] b, input bit s, input string tag);
    int sel_e;
    logic [11:0] exp;
    load = ld; scroll_left = sl; scroll_right = sr; bcd = b; sign = s;
    sel_e = (edge_cnt / 4) % 4;
    exp = {~(4'b0001 << sel_e), model_seg(sel_e), ((sel_e == 0) && (m_off != 0)) ? 1'b0 : 1'b1};
    @(posedge clk);
    edge_cnt++;
    if (ld) begin
      for (int i = 0; i < 5; i++) m_dig[i] = int'(b[4*i +: 4]);
      m_sign = s;
      m_off  = 0;
    end else if (sl && !sr) begin
      if (m_off < 2) m_off++;
    end else if (sr && !sl) begin
      if (m_off > 0) m_off--;
    end
    if (ld || sl || sr)
      $display("txn %s ld=%0d sl=%0d sr=%0d bcd=%h sign=%0d off=%0d", tag, ld, sl, sr, b, s, m_off);
    #1;
    check(tag, {an, seg, dp}, exp);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 20'h0, 1'b0, tag);
  endtask

  initial begin
    logic [19:0] rb;
    logic [19:0] mask;
    int          r;
    int          len;

    vectors = 0;
    miscompares = 0;
    rst_n = 1'b1;
    bcd = '0; sign = 1'b0; load = 1'b0; scroll_left = 1'b0; scroll_right = 1'b0;
    model_reset();

    #1 rst_n = 1'b0;
    #2 check("reset_async", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
    repeat (3) @(posedge clk);
    #1 check("reset_held", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 20'h0, 1'b0, "first_edge");
    check("first_edge_zero", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});
    idle(6, "idle_zero");

    // Signed 1234, then one scroll left to bring the minus into view
    cycle(1'b1, 1'b0, 1'b0, 20'h01234, 1'b1, "load_m1234");
    idle(16, "scan_m1234");
    cycle(1'b0, 1'b1, 1'b0, 20'h0, 1'b0, "left_m1234");
    idle(16, "scan_m1234_off1");

    // Signed zero shows a lone '0' and no minus
    cycle(1'b1, 1'b0, 1'b0, 20'h00000, 1'b1, "load_neg0");
    idle(16, "scan_neg0");

    // Saturation, load override, simultaneous scrolls
    cycle(1'b1, 1'b0, 1'b0, 20'h98765, 1'b1, "load_98765");
    cycle(1'b0, 1'b1, 1'b0, 20'h0, 1'b0, "left1");
    cycle(1'b0, 1'b1, 1'b0, 20'h0, 1'b0, "left2");
    cycle(1'b0, 1'b1, 1'b0, 20'h0, 1'b0, "left3_sat");
    idle(16, "scan_off2");
    cycle(1'b0, 1'b1, 1'b1, 20'h0, 1'b0, "both_ignored");
    idle(4, "scan_both");
    cycle(1'b0, 1'b0, 1'b1, 20'h0, 1'b0, "right1");
    cycle(1'b1, 1'b1, 1'b0, 20'h00042, 1'b0, "load_over_left");
    idle(16, "scan_42");
    cycle(1'b0, 1'b0, 1'b1, 20'h0, 1'b0, "right_sat0");
    idle(4, "scan_right_sat");

    // Out-of-range digit, loaded mid-slot
    idle(2, "pre_E");
    cycle(1'b1, 1'b0, 1'b0, 20'h0A000, 1'b0, "load_0A000");
    idle(18, "scan_0A000");

    // Asynchronous reset in the middle of a slot
    cycle(1'b1, 1'b1, 1'b0, 20'h00777, 1'b1, "load_m777");
    idle(5, "scan_m777");
    #2 rst_n = 1'b0;
    #1 check("reset_mid_scan", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
    model_reset();
    @(posedge clk);
    #1 check("reset_mid_held", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
    rst_n = 1'b1;
    idle(8, "after_reset");

    // Random pulses and values, including A-F digits and leading zeros
    for (int n = 0; n < 400; n++) begin
      r    = $urandom_range(0, 15);
      len  = $urandom_range(0, 5);
      rb   = 20'($urandom);
      mask = (20'd1 << (4 * len)) - 20'd1;
      rb   = rb & mask;
      cycle(r == 0 || r == 4, r == 1 || r == 3 || r == 4, r == 2 || r == 3,
            rb, 1'($urandom), "rand");
    end
    idle(4, "tail");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
